// File: rtl/bcdx_pkg.sv
// Shared definitions for the BCD <-> Excess-3 stream converter:
// FSM state encodings, digit-range limits and direction codes.
package bcdx_pkg;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t CONV = 2'd1;
    localparam state_t DONE = 2'd2;

    // Digit arithmetic constants
    localparam logic [3:0] XS3_OFFSET = 4'd3;
    localparam logic [3:0] BCD_MAX    = 4'd9;
    localparam logic [3:0] XS3_MIN    = 4'd3;
    localparam logic [3:0] XS3_MAX    = 4'd12;

    // Conversion direction, sampled with each accepted word
    localparam logic MODE_TO_XS3 = 1'b0;
    localparam logic MODE_TO_BCD = 1'b1;

endpackage

// File: rtl/xs3_digit_conv.sv
// Single-digit BCD <-> Excess-3 converter with validity check.
// Optional build macro: BCDX_INVALID_SATURATE_EN -- when defined, an invalid
// digit yields 4'hF; otherwise the raw modulo-16 result is passed through.
module xs3_digit_conv
    import bcdx_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       mode_i,
    output logic [3:0] result_o,
    output logic       invalid_o
);

    logic [3:0] raw;
    logic       inv;

    // Offset the digit in the selected direction and range-check the source
    always_comb begin
        raw = 4'd0;
        inv = 1'b0;
        if (mode_i == MODE_TO_XS3) begin
            raw = digit_i + XS3_OFFSET;
            inv = (digit_i > BCD_MAX);
        end else begin
            raw = digit_i - XS3_OFFSET;
            inv = (digit_i < XS3_MIN) || (digit_i > XS3_MAX);
        end
    end

    assign invalid_o = inv;

`ifdef BCDX_INVALID_SATURATE_EN
    assign result_o = inv ? 4'hF : raw;
`else
    assign result_o = raw;
`endif

endmodule

// File: rtl/bcd_xs3_stream_converter.sv
// Multi-digit BCD <-> Excess-3 stream converter. Accepts a packed word over
// valid/ready, converts one digit per clock (LSB first) and presents the
// result with a per-digit error mask until the downstream accepts it.
// Optional build macro: BCDX_INVALID_SATURATE_EN (see xs3_digit_conv).
module bcd_xs3_stream_converter
    import bcdx_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   in_data,
    input  logic                  in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   out_data,
    output logic                  out_err,
    output logic [DIGITS-1:0]     out_err_mask
);

    localparam int unsigned IDXW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

    state_t                state_q, state_d;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0]   data_q, data_d;
    logic                  mode_q, mode_d;
    logic [4*DIGITS-1:0]   res_q, res_d;
    logic [DIGITS-1:0]     mask_q, mask_d;

    logic [3:0]            dig_in;
    logic [3:0]            dig_res;
    logic                  dig_inv;

    assign dig_in = data_q[4*idx_q +: 4];

    xs3_digit_conv u_digit_conv (
        .digit_i   (dig_in),
        .mode_i    (mode_q),
        .result_o  (dig_res),
        .invalid_o (dig_inv)
    );

    // Next-state: accept in IDLE, walk the digits in CONV, hold in DONE
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        mode_d  = mode_q;
        res_d   = res_q;
        mask_d  = mask_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    mode_d  = in_mode;
                    res_d   = '0;
                    mask_d  = '0;
                    idx_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                res_d[4*idx_q +: 4] = dig_res;
                mask_d[idx_q]       = dig_inv;
                idx_d               = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    // Return idx to 0 explicitly so non-power-of-two DIGITS never overruns
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            data_q  <= '0;
            mode_q  <= MODE_TO_XS3;
            res_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            mode_q  <= mode_d;
            res_q   <= res_d;
            mask_q  <= mask_d;
        end
    end

    // Handshake outputs come from registered state only
    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign out_data     = res_q;
    assign out_err_mask = mask_q;
    assign out_err      = |mask_q;

endmodule
